// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressed data memory: FSM state encoding,
// default widths and access latency, and the latency counter width helper.
package dmem_pkg;

  localparam int DMEM_DATA_W        = 8;
  localparam int DMEM_ADDR_W        = 8;
  localparam int DMEM_DEPTH         = 256;
  localparam int DMEM_ACCESS_CYCLES = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } dmem_state_e;

  // A single-cycle access still needs a one-bit counter to hold the value zero.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/dmem_latency_counter.sv
// Loadable down-counter that times a memory access; zero marks the completion
// edge.
module dmem_latency_counter #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_r;

  // Count register: load has priority, decrement saturates at zero.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (dec && (count_r != {WIDTH{1'b0}})) begin
      count_r <= count_r - WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/data_memory.sv
// Multi-cycle byte-addressed data memory with a BUSYWAIT stall handshake.
// Defining DMEM_RANGE_CHECK_EN adds an ERROR output for out-of-range accesses.
module data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_W        = DMEM_DATA_W,
  parameter int ADDR_W        = DMEM_ADDR_W,
  parameter int DEPTH         = DMEM_DEPTH,
  parameter int ACCESS_CYCLES = DMEM_ACCESS_CYCLES
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic [DATA_W-1:0] READDATA,
  output logic              BUSYWAIT
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic              ERROR
`endif
);

  localparam int CNT_W = cnt_width(ACCESS_CYCLES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  dmem_state_e       state_r;
  dmem_state_e       next_state_s;
  logic              busy_s;
  logic              accept_s;
  logic              finish_s;
  logic              cnt_dec_s;
  logic              cnt_zero_s;
  logic              in_range_s;
  logic              op_write_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] readdata_r;
  logic [IDX_W-1:0]  idx_s;
  logic [DATA_W-1:0] mem_r [DEPTH];

  assign idx_s = addr_r[IDX_W-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  logic error_r;

  assign in_range_s = ({1'b0, addr_r} < DEPTH_LIM);
  assign ERROR      = error_r;

  // Error flag rises on the completion edge so it is high for the DONE cycle only.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      error_r <= 1'b0;
    end else begin
      error_r <= finish_s & ~in_range_s;
    end
  end
`else
  assign in_range_s = 1'b1;
`endif

  // Next-state and handshake decode; DONE ignores the still-held request.
  always_comb begin
    next_state_s = state_r;
    busy_s       = 1'b0;
    accept_s     = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        busy_s = READ | WRITE;
        if (READ | WRITE) begin
          accept_s     = 1'b1;
          next_state_s = S_BUSY;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_BUSY: begin
        busy_s = 1'b1;
        if (cnt_zero_s) begin
          finish_s     = 1'b1;
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_BUSY;
        end
      end
      S_DONE: begin
        next_state_s = S_IDLE;
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  assign cnt_dec_s = (state_r == S_BUSY) & ~cnt_zero_s;
  assign BUSYWAIT  = RESET & busy_s;
  assign READDATA  = readdata_r;

  dmem_latency_counter #(
    .WIDTH(CNT_W)
  ) u_latency_counter (
    .CLK       (CLK),
    .RESET     (RESET),
    .load      (accept_s),
    .load_value(CNT_LOAD),
    .dec       (cnt_dec_s),
    .zero      (cnt_zero_s)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Request latch: a simultaneous READ and WRITE is taken as a write.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      op_write_r <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      op_write_r <= WRITE;
      addr_r     <= ADDRESS;
      wdata_r    <= WRITEDATA;
    end else begin
      op_write_r <= op_write_r;
      addr_r     <= addr_r;
      wdata_r    <= wdata_r;
    end
  end

  // Storage array: cleared by reset, written only on the completion edge.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (finish_s && op_write_r && in_range_s) begin
      mem_r[idx_s] <= wdata_r;
    end else begin
      mem_r[idx_s] <= mem_r[idx_s];
    end
  end

  // Load data register; holds across writes and idle cycles.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      readdata_r <= {DATA_W{1'b0}};
    end else if (finish_s && !op_write_r) begin
      readdata_r <= in_range_s ? mem_r[idx_s] : {DATA_W{1'b0}};
    end else begin
      readdata_r <= readdata_r;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; with DMEM_RANGE_CHECK_EN it
// builds the memory with DEPTH=128 and also exercises the ERROR pulse.
module tb_data_memory;

  localparam int AC = 5;
`ifdef DMEM_RANGE_CHECK_EN
  localparam int DEPTH = 128;
`else
  localparam int DEPTH = 256;
`endif

  logic       CLK;
  logic       RESET;
  logic       READ;
  logic       WRITE;
  logic [7:0] ADDRESS;
  logic [7:0] WRITEDATA;
  logic [7:0] READDATA;
  logic       BUSYWAIT;
`ifdef DMEM_RANGE_CHECK_EN
  logic       ERROR;
`endif

  int checks;
  int failures;

  data_memory #(
    .DATA_W       (8),
    .ADDR_W       (8),
    .DEPTH        (DEPTH),
    .ACCESS_CYCLES(AC)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .READ     (READ),
    .WRITE    (WRITE),
    .ADDRESS  (ADDRESS),
    .WRITEDATA(WRITEDATA),
    .READDATA (READDATA),
    .BUSYWAIT (BUSYWAIT)
`ifdef DMEM_RANGE_CHECK_EN
    ,
    .ERROR    (ERROR)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One CPU access, started 1 time unit after an edge; exp_rd is READDATA after completion.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input logic chg, input logic [7:0] exp_rd);
    logic [7:0] prior;
    int n;
    logic exp_err;
    prior   = READDATA;
    exp_err = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
    exp_err = (int'(a) >= DEPTH);
`endif
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    #1;
    check_val("bw_req_cycle", BUSYWAIT, 1'b1);
    n = 0;
    while (BUSYWAIT && n < 40) begin
      @(posedge CLK);
      #1;
      n++;
      if (chg && n == 2) begin
        ADDRESS = 8'h06;
        WRITEDATA = 8'hFF;
      end
      if (n == AC) begin
        check_val("rd_hold_before_commit", READDATA, prior);
      end
    end
    check_val("latency_edges", n, AC + 1);
    check_val("rd_done", READDATA, exp_rd);
`ifdef DMEM_RANGE_CHECK_EN
    check_val("err_done", ERROR, exp_err);
`endif
    READ = 1'b0; WRITE = 1'b0;
    tick();
    check_val("bw_idle", BUSYWAIT, 1'b0);
    check_val("rd_idle", READDATA, exp_rd);
`ifdef DMEM_RANGE_CHECK_EN
    check_val("err_idle", ERROR, 1'b0);
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    RESET = 1'b0; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h10; WRITEDATA = 8'h00;
    #1;
    check_val("bw_forced_low_in_reset", BUSYWAIT, 1'b0);
    tick();
    check_val("rst_readdata", READDATA, 8'h00);
    check_val("rst_bw", BUSYWAIT, 1'b0);
    READ = 1'b0; RESET = 1'b1;
    tick();

    // Read of cleared memory, then write/read-back
    access(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00);
    access(1'b0, 1'b1, 8'h2A, 8'hC3, 1'b0, 8'h00);
    access(1'b1, 1'b0, 8'h2A, 8'h00, 1'b0, 8'hC3);

    // Inputs changed during BUSY must be ignored
    access(1'b0, 1'b1, 8'h05, 8'h77, 1'b1, 8'hC3);
    access(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 8'h77);
    access(1'b1, 1'b0, 8'h06, 8'h00, 1'b0, 8'h00);

    // Simultaneous READ and WRITE is a write
    access(1'b1, 1'b1, 8'h40, 8'h9A, 1'b0, 8'h00);
    access(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 8'h9A);

    // Reset in the middle of a store
    WRITE = 1'b1; ADDRESS = 8'h50; WRITEDATA = 8'h33;
    #1;
    check_val("bw_store_req", BUSYWAIT, 1'b1);
    repeat (3) tick();
    check_val("bw_store_busy", BUSYWAIT, 1'b1);
    RESET = 1'b0;
    #1;
    check_val("bw_abort_reset", BUSYWAIT, 1'b0);
    tick();
    check_val("rd_after_abort", READDATA, 8'h00);
    WRITE = 1'b0; RESET = 1'b1;
    tick();
    check_val("bw_after_abort", BUSYWAIT, 1'b0);
    access(1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 8'h00);
    access(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 8'h00);

`ifdef DMEM_RANGE_CHECK_EN
    // Out-of-range accesses: no write, READDATA cleared, ERROR pulse
    access(1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 8'h00);
    access(1'b0, 1'b1, 8'h80, 8'h11, 1'b0, 8'h00);
    access(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h5A);
    access(1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 8'h00);
    access(1'b0, 1'b1, 8'h7F, 8'h3C, 1'b0, 8'h00);
    access(1'b1, 1'b0, 8'h7F, 8'h00, 1'b0, 8'h3C);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Byte-addressed data memory serving the processor's load/store path.
- Consumes register-file OUT1 as store data and the ALU result as address.
- Returns load data to the register-file write port.
- Multi-cycle access with a BUSYWAIT handshake stalls the CPU until the access completes; it is the first level of the memory hierarchy.

Parameters:
- DATA_W, 8, data width in bits.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of bytes stored (must be ≤ 2^ADDR_W).
- ACCESS_CYCLES, 5, clock edges from request acceptance to completion (≥1).

Ports:
- CLK  in  1  clock, all state changes on posedge.
- RESET  in  1  synchronous, active-low reset (0 = reset).
- READ  in  1  load request, held by CPU until BUSYWAIT falls.
- WRITE  in  1  store request, held by CPU until BUSYWAIT falls.
- ADDRESS  in  ADDR_W  byte address.
- WRITEDATA  in  DATA_W  store data.
- READDATA  out  DATA_W  load data.
- BUSYWAIT  out  1  CPU stall request.

Behaviour:
- Reset:
  - On posedge with RESET=0: state=IDLE, counter=0, READDATA=0, all DEPTH bytes cleared to 0, latched request discarded.
  - BUSYWAIT is forced 0 while RESET=0.
  - Reset mid-access aborts the access; a pending write is never committed.
- States IDLE, BUSY, DONE:
  - IDLE: BUSYWAIT = READ|WRITE, combinational, so the CPU stalls in the request cycle. On posedge with READ|WRITE=1, latch op, ADDRESS and WRITEDATA; counter=ACCESS_CYCLES-1; go BUSY.
  - BUSY: BUSYWAIT=1. Each posedge with counter≠0, decrement. On posedge with counter==0:
    - write: mem[latched addr] <= latched data.
    - read: READDATA <= mem[latched addr].
    - Then go DONE.
  - DONE: BUSYWAIT=0 for exactly one cycle. READ/WRITE are ignored, because the CPU still holds the completed instruction's request. Next posedge goes IDLE.
- Latency: request presented in cycle 0 → BUSYWAIT high cycles 0..ACCESS_CYCLES, low in cycle ACCESS_CYCLES+1 (DONE). READDATA valid from posedge ACCESS_CYCLES onward.
- READDATA holds its value until the next read completes or reset; writes never change it.
- READ and WRITE both high at acceptance: treated as a write; READDATA is unchanged.
- Inputs changing during BUSY have no effect; only the latched values are used.
- Address bits beyond log2(DEPTH) are ignored (wrap modulo DEPTH) unless the range-check feature is enabled.
- ACCESS_CYCLES=1: BUSY lasts one cycle; counter starts at 0.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined:
  - Adds output ERROR (1 bit, reset 0).
  - Any accepted access with ADDRESS ≥ DEPTH completes with normal timing.
  - On such an access: write suppressed, READDATA <= 0, ERROR pulses high for the DONE cycle only.
- Undefined: no ERROR port; addresses wrap modulo DEPTH.

Decomposition:
- Shared package dmem_pkg:
  - State encoding constants S_IDLE=2'd0, S_BUSY=2'd1, S_DONE=2'd2.
  - DATA_W/ADDR_W defaults.
  - Default ACCESS_CYCLES.
- One sub-module, dmem_latency_counter:
  - Loadable down-counter with load, decrement enable and zero flag, width $clog2(ACCESS_CYCLES).
  - Instantiated by data_memory.
- Storage array and FSM stay in data_memory.

Test Plan:
- Reset, then RESET=1; READ, ADDRESS=8'h10 → BUSYWAIT high cycles 0..5, READDATA=8'h00 at posedge 5, BUSYWAIT=0 in cycle 6.
- WRITE, ADDRESS=8'h2A, WRITEDATA=8'hC3; after BUSYWAIT falls, READ 8'h2A → READDATA=8'hC3 exactly 5 edges after the read is accepted; READDATA unchanged during the write.
- WRITE 8'h05 data 8'h77; change WRITEDATA to 8'hFF and ADDRESS to 8'h06 during BUSY → mem[5]=8'h77, mem[6] unchanged (read back both).
- READ and WRITE both high, ADDRESS=8'h40, WRITEDATA=8'h9A → write performed; READDATA keeps its prior value; later read of 8'h40 → 8'h9A.
- Store issued, RESET=0 at posedge 3 of BUSY → BUSYWAIT=0 immediately, state IDLE; subsequent read of that address → 8'h00.
- With DMEM_RANGE_CHECK_EN and DEPTH=128: WRITE 8'h80 data 8'h11 → ERROR=1 only in DONE cycle; read 8'h00 unchanged; READ 8'h80 → READDATA=8'h00, ERROR pulse.
